// File: rtl/uart_tx_pacer.sv
// uart_tx_pacer: byte FIFO that releases one byte per UART frame as a transmit strobe
module uart_tx_pacer #(
    parameter int CLOCKFRQ     = 240000000,
    parameter int BAUDRATE     = 3500000,
    parameter int CLOCK_DIVIDE = CLOCKFRQ / (BAUDRATE * 4),
    parameter int FRAME_CLKS   = 44 * CLOCK_DIVIDE + 8,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [7:0]            wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic                  flush_i,
    output logic                  transmit_o,
    output logic [7:0]            tx_byte_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic [7:0]            drop_count_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int GW    = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;

    typedef enum logic {IDLE, GAP} state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [7:0]            drop_q, drop_d;
    logic                  overflow_q;
    logic                  transmit_q;
    logic [7:0]            tx_byte_q;
    logic [GW-1:0]         gap_q;
    state_t                state_q;
    logic                  push, pop, reject;

    assign empty_o      = level_q == '0;
    assign full_o       = level_q == LW'(DEPTH);
    assign wr_ready_o   = !full_o;
    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;
    assign transmit_o   = transmit_q;
    assign tx_byte_o    = tx_byte_q;

    // A flushed write is discarded outright: neither stored nor counted as a drop.
    assign push   = wr_valid_i && !full_o && !flush_i;
    assign reject = wr_valid_i && full_o && !flush_i;
    assign pop    = state_q == IDLE && !empty_o;

    // Next-state pointer, level and drop-counter arithmetic.
    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + DEPTH_LOG2'(pop);
        level_d  = flush_i ? '0 : level_q + LW'(push) - LW'(pop);
        drop_d   = (reject && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    // Byte storage; stale contents are harmless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (nRst && push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            overflow_q <= reject;
        end
    end

    // Pacer: strobe the head byte, then wait out a full frame before the next one.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
        end else if (state_q == IDLE) begin
            transmit_q <= pop;
            if (pop) begin
                tx_byte_q <= mem_q[rd_ptr_q];
                gap_q     <= GW'(FRAME_CLKS - 2);
                state_q   <= GAP;
            end
        end else begin
            transmit_q <= 1'b0;
            if (gap_q == '0) state_q <= IDLE;
            else gap_q <= gap_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_pacer.sv
// tb_uart_tx_pacer: directed checks of FIFO, pacing, flush, overflow and reset
module tb_uart_tx_pacer;
    localparam int F = 756;

    logic       clk = 1'b0;
    logic       nRst;
    logic [7:0] wr_data_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic       flush_i;
    logic       transmit_o;
    logic [7:0] tx_byte_o;
    logic [4:0] level_o;
    logic       empty_o;
    logic       full_o;
    logic       overflow_o;
    logic [7:0] drop_count_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n, s, ovf;

    uart_tx_pacer dut (
        .clk(clk), .nRst(nRst), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o), .flush_i(flush_i), .transmit_o(transmit_o),
        .tx_byte_o(tx_byte_o), .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
        .overflow_o(overflow_o), .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic run(input int cycles, output int strobes);
        strobes = 0;
        repeat (cycles) begin
            cyc();
            if (transmit_o) strobes++;
        end
    endtask

    task automatic wait_strobe(input int max, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!transmit_o && cnt < max);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; wr_data_i = '0; wr_valid_i = 1'b0; flush_i = 1'b0;
        cyc(); cyc();
        chk("rst_transmit", 32'(transmit_o), 32'h0);
        chk("rst_tx_byte", 32'(tx_byte_o), 32'h0);
        chk("rst_level", 32'(level_o), 32'h0);
        chk("rst_empty", 32'(empty_o), 32'h1);
        chk("rst_ready", 32'(wr_ready_o), 32'h1);
        chk("rst_drop", 32'(drop_count_o), 32'h0);
        nRst = 1'b1;
        // single byte
        wr_data_i = 8'hA5; wr_valid_i = 1'b1; cyc(); wr_valid_i = 1'b0;
        chk("t1_no_strobe_yet", 32'(transmit_o), 32'h0);
        chk("t1_level1", 32'(level_o), 32'h1);
        cyc();
        chk("t1_strobe", 32'(transmit_o), 32'h1);
        chk("t1_byte", 32'(tx_byte_o), 32'hA5);
        chk("t1_level0", 32'(level_o), 32'h0);
        cyc();
        chk("t1_one_cycle", 32'(transmit_o), 32'h0);
        chk("t1_hold", 32'(tx_byte_o), 32'hA5);
        run(F, s);
        chk("t1_no_more", 32'(s), 32'h0);
        // burst of three
        wr_valid_i = 1'b1; wr_data_i = 8'h01; cyc();
        chk("t2_level_a", 32'(level_o), 32'h1);
        wr_data_i = 8'h02; cyc();
        chk("t2_strobe1", 32'(transmit_o), 32'h1);
        chk("t2_byte1", 32'(tx_byte_o), 32'h01);
        chk("t2_level_b", 32'(level_o), 32'h1);
        wr_data_i = 8'h03; cyc(); wr_valid_i = 1'b0;
        chk("t2_level_c", 32'(level_o), 32'h2);
        wait_strobe(F + 10, n);
        chk("t2_gap2", 32'(n), 32'(F - 1));
        chk("t2_byte2", 32'(tx_byte_o), 32'h02);
        wait_strobe(F + 10, n);
        chk("t2_gap3", 32'(n), 32'(F));
        chk("t2_byte3", 32'(tx_byte_o), 32'h03);
        chk("t2_empty", 32'(empty_o), 32'h1);
        run(F + 2, s);
        chk("t2_no_more", 32'(s), 32'h0);
        // overflow while the pacer sits in GAP
        wr_data_i = 8'hAA; wr_valid_i = 1'b1; cyc(); wr_valid_i = 1'b0; cyc();
        chk("t3_strobe", 32'(tx_byte_o), 32'hAA);
        ovf = 0;
        wr_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data_i = 8'(i); cyc();
            if (overflow_o) ovf++;
        end
        chk("t3_ovf_pulses", 32'(ovf), 32'd4);
        chk("t3_drop4", 32'(drop_count_o), 32'd4);
        chk("t3_full", 32'(full_o), 32'h1);
        chk("t3_ready", 32'(wr_ready_o), 32'h0);
        chk("t3_level16", 32'(level_o), 32'd16);
        run(300, s);
        chk("t3_drop_sat", 32'(drop_count_o), 32'hFF);
        chk("t3_ovf_hi", 32'(overflow_o), 32'h1);
        flush_i = 1'b1; cyc(); flush_i = 1'b0; wr_valid_i = 1'b0;
        chk("t3_flush_no_ovf", 32'(overflow_o), 32'h0);
        chk("t3_flush_level", 32'(level_o), 32'h0);
        // reset mid-GAP with three bytes queued
        wr_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data_i = 8'(8'h20 + i); cyc();
        end
        wr_valid_i = 1'b0;
        chk("t5_level3", 32'(level_o), 32'h3);
        chk("t5_still_gap", 32'(transmit_o), 32'h0);
        nRst = 1'b0; cyc(); nRst = 1'b1;
        chk("t5_transmit", 32'(transmit_o), 32'h0);
        chk("t5_level", 32'(level_o), 32'h0);
        chk("t5_tx_byte", 32'(tx_byte_o), 32'h0);
        chk("t5_drop", 32'(drop_count_o), 32'h0);
        wr_data_i = 8'h5A; wr_valid_i = 1'b1; cyc(); wr_valid_i = 1'b0;
        chk("t5_wait", 32'(transmit_o), 32'h0);
        cyc();
        chk("t5_strobe", 32'(transmit_o), 32'h1);
        chk("t5_byte", 32'(tx_byte_o), 32'h5A);
        // flush during GAP keeps the spacing
        wr_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data_i = 8'(8'h11 + i); cyc();
        end
        chk("t4_level5", 32'(level_o), 32'h5);
        wr_data_i = 8'h77; flush_i = 1'b1; cyc(); flush_i = 1'b0;
        chk("t4_flush_level", 32'(level_o), 32'h0);
        chk("t4_flush_nodrop", 32'(drop_count_o), 32'h0);
        wr_data_i = 8'h3C; cyc(); wr_valid_i = 1'b0;
        wait_strobe(F + 10, n);
        chk("t4_gap_kept", 32'(n), 32'(F - 7));
        chk("t4_byte", 32'(tx_byte_o), 32'h3C);
        // write on the pop edge at level 1
        wr_data_i = 8'h44; wr_valid_i = 1'b1; cyc(); wr_valid_i = 1'b0;
        run(F - 2, s);
        chk("t6_quiet", 32'(s), 32'h0);
        chk("t6_level1", 32'(level_o), 32'h1);
        wr_data_i = 8'h45; wr_valid_i = 1'b1; cyc(); wr_valid_i = 1'b0;
        chk("t6_strobe", 32'(transmit_o), 32'h1);
        chk("t6_byte44", 32'(tx_byte_o), 32'h44);
        chk("t6_level_kept", 32'(level_o), 32'h1);
        wait_strobe(F + 10, n);
        chk("t6_gap", 32'(n), 32'(F));
        chk("t6_byte45", 32'(tx_byte_o), 32'h45);
        chk("t6_empty", 32'(level_o), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
